// File: rtl/fc_score_collector_if.sv
// Stream interface between the FC layer, the score collector and the argmax stage.
// The master side drives scores and accepts packed frames; the slave side is the collector.
interface fc_score_collector_if #(
  parameter int NUM_CLASS = 10,
  parameter int SCORE_W   = 16,
  parameter int ACC_W     = 32
);
  logic                         in_valid;
  logic                         in_ready;
  logic [ACC_W-1:0]             in_data;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_CLASS*SCORE_W-1:0] out_data;
  logic                         out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/fc_score_collector.sv
// Ping-pong collector packing ten FC scores per frame into one 160-bit word.
// Optional macro SCORE_SAT_EN: saturate scores to the signed 16-bit range instead of truncating.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | writing beats into buffer wr_sel; in_ready = !full[wr_sel]
// DROP    | long frame already closed; discard beats up to in_last
module fc_score_collector #(
  parameter int NUM_CLASS = 10,
  parameter int SCORE_W   = 16,
  parameter int ACC_W     = 32
) (
  input logic                clk,
  input logic                rst_n,
  fc_score_collector_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_CLASS);
  localparam logic [CNT_W-1:0]   LAST_BEAT   = CNT_W'(NUM_CLASS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MIN   = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic [SCORE_W-1:0] SCORE_MAX   = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic [NUM_CLASS-1:0][SCORE_W-1:0] EMPTY_FRAME = {NUM_CLASS{SCORE_MIN}};

  typedef enum logic {COLLECT, DROP} state_t;

  state_t                             state_q, state_d;
  logic                               wr_sel_q, wr_sel_d;
  logic                               rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]                   beat_cnt_q, beat_cnt_d;
  logic [1:0]                         full_q, full_d;
  logic [1:0]                         err_q, err_d;
  logic [NUM_CLASS-1:0][SCORE_W-1:0]  frame_q [2];
  logic [NUM_CLASS-1:0][SCORE_W-1:0]  frame_d [2];
  logic                               in_ready_q, in_ready_d;
  logic                               out_valid_q, out_valid_d;
  logic                               out_err_q, out_err_d;
  logic [NUM_CLASS-1:0][SCORE_W-1:0]  out_data_q, out_data_d;

  logic               in_hs;
  logic               out_hs;
  logic               last_beat;
  logic [SCORE_W-1:0] score_narrow;

`ifdef SCORE_SAT_EN
  always_comb begin
    score_narrow = bus.in_data[SCORE_W-1:0];
    // Out of range whenever the bits above the 16-bit sign are not a pure sign extension.
    if (bus.in_data[ACC_W-1:SCORE_W-1] != {(ACC_W-SCORE_W+1){bus.in_data[ACC_W-1]}})
      score_narrow = bus.in_data[ACC_W-1] ? SCORE_MIN : SCORE_MAX;
  end
`else
  logic unused_in_msbs;
  assign unused_in_msbs = ^bus.in_data[ACC_W-1:SCORE_W];
  assign score_narrow   = bus.in_data[SCORE_W-1:0];
`endif

  assign in_hs     = bus.in_valid & in_ready_q;
  assign out_hs    = full_q[rd_sel_q] & bus.out_ready;
  assign last_beat = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    state_d    = state_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    beat_cnt_d = beat_cnt_q;
    full_d     = full_q;
    err_d      = err_q;
    frame_d    = frame_q;

    if (out_hs) begin
      full_d[rd_sel_q]  = 1'b0;
      err_d[rd_sel_q]   = 1'b0;
      frame_d[rd_sel_q] = EMPTY_FRAME;
      rd_sel_d          = ~rd_sel_q;
    end

    // A close only happens into an empty buffer, so it never collides with the release above.
    if (in_hs) begin
      if (state_q == DROP) begin
        if (bus.in_last) state_d = COLLECT;
      end else begin
        frame_d[wr_sel_q][LAST_BEAT - beat_cnt_q] = score_narrow;
        if (bus.in_last || last_beat) begin
          full_d[wr_sel_q] = 1'b1;
          err_d[wr_sel_q]  = !(bus.in_last && last_beat);
          wr_sel_d         = ~wr_sel_q;
          beat_cnt_d       = '0;
          if (!bus.in_last) state_d = DROP;
        end else begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
    end

    in_ready_d  = (state_d == DROP) || !full_d[wr_sel_d];
    out_valid_d = full_d[rd_sel_d];
    out_err_d   = err_d[rd_sel_d];
    out_data_d  = frame_d[rd_sel_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      beat_cnt_q  <= '0;
      full_q      <= '0;
      err_q       <= '0;
      frame_q[0]  <= EMPTY_FRAME;
      frame_q[1]  <= EMPTY_FRAME;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= EMPTY_FRAME;
    end else begin
      state_q     <= state_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      beat_cnt_q  <= beat_cnt_d;
      full_q      <= full_d;
      err_q       <= err_d;
      frame_q[0]  <= frame_d[0];
      frame_q[1]  <= frame_d[1];
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_fc_score_collector.sv
// Directed bench for fc_score_collector: a frame table plus hand-written
// backpressure, latency and mid-frame reset sequences.
module tb_fc_score_collector;
  localparam logic [159:0] EMPTY = {10{16'h8000}};
  localparam logic [159:0] SEQ10 = 160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A;

  typedef struct packed {
    logic [3:0]        n;
    logic [11:0][31:0] d;
    logic [159:0]      exp_data;
    logic              exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [7];

  fc_score_collector_if bus();

  fc_score_collector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got=stalled expected=accept within 50 cycles");
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_seq10(input logic [31:0] base);
    for (int i = 0; i < 10; i++) send_beat(base + 32'(i + 1), i == 9);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0].n = 4'd10; vecs[0].d = '0;
    for (int i = 0; i < 10; i++) vecs[0].d[i] = 32'(i + 1);
    vecs[0].exp_data = SEQ10; vecs[0].exp_err = 1'b0;

    vecs[1].n = 4'd3; vecs[1].d = '0;
    vecs[1].d[0] = 32'd5; vecs[1].d[1] = 32'hFFFF_FFFE; vecs[1].d[2] = 32'd7;
    vecs[1].exp_data = {16'h0005, 16'hFFFE, 16'h0007, {7{16'h8000}}}; vecs[1].exp_err = 1'b1;

    vecs[2].n = 4'd1; vecs[2].d = '0; vecs[2].d[0] = 32'h0000_1234;
    vecs[2].exp_data = {16'h1234, {9{16'h8000}}}; vecs[2].exp_err = 1'b1;

    vecs[3].n = 4'd12; vecs[3].d = '0;
    for (int i = 0; i < 12; i++) vecs[3].d[i] = 32'(i + 11);
    vecs[3].exp_data = 160'h000B_000C_000D_000E_000F_0010_0011_0012_0013_0014; vecs[3].exp_err = 1'b1;

    vecs[4].n = 4'd10; vecs[4].d = '0;
    for (int i = 0; i < 10; i++) vecs[4].d[i] = -32'(i + 1);
    vecs[4].exp_data = 160'hFFFF_FFFE_FFFD_FFFC_FFFB_FFFA_FFF9_FFF8_FFF7_FFF6; vecs[4].exp_err = 1'b0;

    vecs[5].n = 4'd10; vecs[5].d = '0;
    vecs[5].d[0] = 32'h0001_2345; vecs[5].d[1] = 32'hFFFE_0000; vecs[5].d[2] = 32'h0000_7FFF;
    vecs[5].d[3] = 32'hFFFF_8000; vecs[5].d[4] = 32'h0000_8000;
    for (int i = 5; i < 10; i++) vecs[5].d[i] = 32'(i + 1);
`ifdef SCORE_SAT_EN
    vecs[5].exp_data = 160'h7FFF_8000_7FFF_8000_7FFF_0006_0007_0008_0009_000A;
`else
    vecs[5].exp_data = 160'h2345_0000_7FFF_8000_8000_0006_0007_0008_0009_000A;
`endif
    vecs[5].exp_err = 1'b0;

    vecs[6].n = 4'd9; vecs[6].d = '0;
    for (int i = 0; i < 9; i++) vecs[6].d[i] = 32'(i + 1);
    vecs[6].exp_data = 160'h0001_0002_0003_0004_0005_0006_0007_0008_0009_8000; vecs[6].exp_err = 1'b1;

    // Reset values
    repeat (2) tick();
    check("rst_out_valid", {159'd0, bus.out_valid}, 160'd0);
    check("rst_out_err",   {159'd0, bus.out_err},   160'd0);
    check("rst_out_data",  bus.out_data,            EMPTY);
    check("rst_in_ready",  {159'd0, bus.in_ready},  160'd1);
    rst_n = 1'b1;
    tick();

    // Frame table
    for (int v = 0; v < 7; v++) begin
      for (int b = 0; b < int'(vecs[v].n); b++)
        send_beat(vecs[v].d[b], b == int'(vecs[v].n) - 1);
      check($sformatf("vec%0d_valid", v), {159'd0, bus.out_valid}, 160'd1);
      check($sformatf("vec%0d_data", v),  bus.out_data, vecs[v].exp_data);
      check($sformatf("vec%0d_err", v),   {159'd0, bus.out_err}, {159'd0, vecs[v].exp_err});
      consume();
      check($sformatf("vec%0d_drain", v), {159'd0, bus.out_valid}, 160'd0);
    end

    // Latency: out_valid appears the cycle after the closing beat, consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_beat(32'(i + 1), 1'b0);
    check("lat_not_early", {159'd0, bus.out_valid}, 160'd0);
    send_beat(32'd10, 1'b1);
    check("lat_valid", {159'd0, bus.out_valid}, 160'd1);
    check("lat_data",  bus.out_data, SEQ10);
    tick();
    check("lat_consumed", {159'd0, bus.out_valid}, 160'd0);
    bus.out_ready = 1'b0;

    // Backpressure: two frames fill both buffers, third stalls
    send_seq10(32'h0);
    send_seq10(32'h100);
    check("bp_in_ready_low", {159'd0, bus.in_ready}, 160'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0201;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_stall%0d", i), {159'd0, bus.in_ready}, 160'd0);
      check($sformatf("bp_hold%0d", i),  bus.out_data, SEQ10);
    end
    consume();
    check("bp_second_frame", bus.out_data, 160'h0101_0102_0103_0104_0105_0106_0107_0108_0109_010A);
    check("bp_ready_rise",   {159'd0, bus.in_ready}, 160'd1);
    send_seq10(32'h200);
    check("bp_third_valid", {159'd0, bus.out_valid}, 160'd1);
    consume();
    check("bp_third_frame", bus.out_data, 160'h0201_0202_0203_0204_0205_0206_0207_0208_0209_020A);
    check("bp_third_err",   {159'd0, bus.out_err}, 160'd0);
    consume();
    check("bp_drained", {159'd0, bus.out_valid}, 160'd0);

    // Reset mid-frame with a pending full buffer
    send_seq10(32'h300);
    for (int i = 0; i < 4; i++) send_beat(32'(i + 1), 1'b0);
    check("mr_pending", {159'd0, bus.out_valid}, 160'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", {159'd0, bus.out_valid}, 160'd0);
    check("mr_data",  bus.out_data, EMPTY);
    check("mr_ready", {159'd0, bus.in_ready}, 160'd1);
    tick();
    rst_n = 1'b1;
    tick();
    send_seq10(32'h0);
    check("mr_fresh_valid", {159'd0, bus.out_valid}, 160'd1);
    check("mr_fresh_data",  bus.out_data, SEQ10);
    check("mr_fresh_err",   {159'd0, bus.out_err}, 160'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fc_score_collector.md
# fc_score_collector

- Collects the ten per-class scores that the final fully-connected layer streams out one per beat.
- Narrows each score from the accumulator width to 16 bits and packs one inference's scores into a single 160-bit word.
- The packed layout is the one the argmax/compare stage consumes: class 10 in [159:144], down to class 1 in [15:0].
- Two ping-pong frame buffers decouple the FC output stream from the downstream consumer, so input and output proceed concurrently.

## Interface

Parameters:
- NUM_CLASS, 10, number of scores per frame
- SCORE_W, 16, packed score width (signed)
- ACC_W, 32, incoming accumulator width (signed)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  score beat valid
- in_ready  output  1  collector can accept a beat
- in_data  input  ACC_W  signed accumulator score
- in_last  input  1  marks last beat of a frame
- out_valid  output  1  packed frame available
- out_ready  input  1  consumer accepts frame
- out_data  output  NUM_CLASS*SCORE_W  packed frame; class k in bits [k*SCORE_W-1 -: SCORE_W]
- out_err  output  1  frame length was not NUM_CLASS; qualified by out_valid

## Operation

Buffers and beat mapping:
- Two buffers, B0 and B1. Each holds NUM_CLASS slots plus an err flag and a full flag.
- wr_sel selects the buffer being filled; rd_sel selects the buffer presented on out_data.
- Beat i of a frame (i = 0..NUM_CLASS-1, counted by beat_cnt) writes slot class (NUM_CLASS-i).
  - First beat goes to bits [159:144].
  - Tenth beat goes to bits [15:0].

Narrowing:
- The written value is in_data narrowed to SCORE_W bits; see Configuration.

Frame close:
- A frame closes on the handshake (in_valid & in_ready) that either carries in_last or is beat NUM_CLASS-1, whichever comes first.
- Exact frame: in_last on beat NUM_CLASS-1. The err flag stays 0.
- Short frame: in_last on beat i < NUM_CLASS-1.
  - Unwritten slots keep 16'h8000, so argmax never selects them.
  - err flag = 1.
- Long frame: beat NUM_CLASS-1 arrives without in_last.
  - The frame closes with err = 1.
  - The collector enters DROP state.

On close:
- Set full[wr_sel]; toggle wr_sel; clear beat_cnt.

State machine:
- COLLECT (reset state) → DROP on a long-frame close.
- DROP: in_ready = 1; beats are accepted and discarded; return to COLLECT on the handshake carrying in_last.
- In COLLECT: in_ready = !full[wr_sel].

Output side:
- out_valid = full[rd_sel].
- out_data and out_err are driven from buffer rd_sel.
- On out_valid & out_ready:
  - Clear full[rd_sel].
  - Reinitialise all slots of that buffer to 16'h8000 and clear its err flag.
  - Toggle rd_sel.

## Timing

Reset values:
- out_valid = 0, out_err = 0, out_data = {10{16'h8000}}.
- in_ready = 1; state = COLLECT.
- wr_sel = rd_sel = 0, beat_cnt = 0, both buffers empty.

Latency and throughput:
- The closing beat is written at edge N; out_valid = 1 in the cycle after edge N.
- Sustains 1 beat/cycle with no bubbles between back-to-back frames while the consumer keeps up.

Output stability:
- out_data and out_err stay stable while out_valid = 1 and out_ready = 0.

Backpressure:
- When both buffers are full, in_ready = 0; input stalls without losing data.
- A release and a close in the same cycle act on different buffers.
  - If the released buffer is the one wr_sel points to, in_ready rises the next cycle.

Boundary cases:
- Reset asserted mid-frame discards the partial frame and any pending full buffers immediately (asynchronous clear).
- in_last on beat 0 is a one-slot short frame: slot 10 holds the value, slots 9..1 = 16'h8000, err = 1.

## Configuration

SCORE_SAT_EN:
- Defined: in_data saturates to [-32768, 32767].
  - Values > 32767 become 16'h7FFF.
  - Values < -32768 become 16'h8000.
- Undefined: in_data[SCORE_W-1:0] is taken by plain truncation.

## Test plan

- Reset, then stream scores 1..10 (in_data = 1..10, in_last on beat 10), out_ready = 1 → one cycle after the last beat, out_valid = 1, out_data = 160'h0001_0002_…_000A, out_err = 0.
- Two back-to-back frames with out_ready = 0 → both accepted, in_ready drops to 0 on the following cycle; a third frame stalls. Raise out_ready → frames emerge in order with no corruption.
- Short frame: 3 beats (5, -2, 7) with in_last on beat 3 → out_data[159:112] = 0005_FFFE_0007, remaining slots 16'h8000, out_err = 1.
- Long frame: 12 beats, in_last on beat 12 → frame closes after beat 10 with out_err = 1; beats 11-12 discarded; the next frame packs correctly with err = 0.
- in_data = 32'h0001_2345 → out slot = 16'h7FFF with SCORE_SAT_EN defined, 16'h2345 without.
- Assert rst_n low after beat 4 of a frame → outputs return to reset values immediately; a fresh full frame after release packs correctly.
